// File: rtl/yc_pkg.sv
// Shared token encoding and controller states for the red-cell port.
// A Morphle wire pair carries 00 for empty, 01 for zero, 10 for one; 11 never occurs legally.
package yc_pkg;

    localparam logic [1:0] TK_EMPTY   = 2'b00;
    localparam logic [1:0] TK_ZERO    = 2'b01;
    localparam logic [1:0] TK_ONE     = 2'b10;
    localparam logic [1:0] TK_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2,
        ERROR   = 2'd3
    } state_t;

    function automatic logic is_data(input logic [1:0] tk);
        return (tk == TK_ZERO) || (tk == TK_ONE);
    endfunction

    function automatic logic [1:0] bit_to_token(input logic b);
        return b ? TK_ONE : TK_ZERO;
    endfunction

endpackage

// File: rtl/yc_tok_sync.sv
// Brings the asynchronous 2-wire token from the column into the clock domain and
// only passes on values seen identically on two consecutive clocks.
module yc_tok_sync
    import yc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] col_back,
    output logic [1:0] bq
);

    logic [SYNC_STAGES-1:0][1:0] stages;
    logic [1:0]                  bs;
    logic [1:0]                  bs_prev;

    assign bs = stages[SYNC_STAGES-1];

    // The two wires of a token may settle at slightly different times, so a
    // transient code is dropped unless it persists for two samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages  <= '0;
            bs_prev <= TK_EMPTY;
            bq      <= TK_EMPTY;
        end else begin
            stages  <= {stages[SYNC_STAGES-2:0], col_back};
            bs_prev <= bs;
            if (bs == bs_prev) begin
                bq <= bs;
            end
        end
    end

endmodule

// File: rtl/yc_redport.sv
// Red cell: feeds single bits from a valid/ready stream into the top of a Morphle
// column as 2-wire tokens and returns the column result on a second stream.
module yc_redport
    import yc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_bit,
    output logic       err,
    output logic       col_uempty,
    output logic [1:0] col_out,
    input  logic [1:0] col_back
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t               state;
    logic [TIMEOUT_W-1:0] counter;
    logic [1:0]           bq;
    logic                 live;
    logic                 timed_out;

    yc_tok_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .col_back(col_back),
        .bq      (bq)
    );

    assign col_uempty = 1'b0;
    assign timed_out  = (TIMEOUT != 0) && (counter == TO_LAST);

    // live holds in_ready low while reset is asserted and for the first edge after it.
    assign in_ready = live && (state == IDLE) && !res_valid && (bq == TK_EMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col_out   <= TK_EMPTY;
            res_valid <= 1'b0;
            res_bit   <= 1'b0;
            err       <= 1'b0;
            counter   <= '0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    col_out <= TK_EMPTY;
                    if (in_valid && in_ready) begin
                        col_out <= bit_to_token(in_bit);
                        counter <= '0;
                        state   <= DRIVE;
                    end
                end
                // A result can only be set here while the buffer is known empty.
                DRIVE: begin
                    if (is_data(bq)) begin
                        res_bit   <= bq[1];
                        res_valid <= 1'b1;
                        col_out   <= TK_EMPTY;
                        counter   <= '0;
                        state     <= RELEASE;
                    end else if ((bq == TK_ILLEGAL) || timed_out) begin
                        col_out <= TK_EMPTY;
                        err     <= 1'b1;
                        state   <= ERROR;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + 1'b1;
                    end
                end
                RELEASE: begin
                    col_out <= TK_EMPTY;
                    if (bq == TK_EMPTY) begin
                        state <= IDLE;
                    end else if ((bq == TK_ILLEGAL) || timed_out) begin
                        err   <= 1'b1;
                        state <= ERROR;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + 1'b1;
                    end
                end
                ERROR: begin
                    col_out <= TK_EMPTY;
                    err     <= 1'b1;
                end
                default: begin
                    col_out <= TK_EMPTY;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yc_redport.sv
// Directed bench for yc_redport with a behavioural column model (echo, NOT, or
// manually driven wires) and a second instance with the timeout disabled.
module tb_yc_redport;
    import yc_pkg::*;

    localparam int SYNC       = 2;
    localparam int COL_MANUAL = 0;
    localparam int COL_ECHO   = 1;
    localparam int COL_NOT    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_bit;
    logic       res_valid, res_ready, res_bit;
    logic       err, col_uempty;
    logic [1:0] col_out, col_back;

    logic       in_valid_nt, in_ready_nt, res_valid_nt, res_bit_nt, err_nt, col_uempty_nt;
    logic [1:0] col_out_nt;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         col_mode = COL_MANUAL;
    logic [1:0] man_back = TK_EMPTY;
    logic [1:0] hist [5];
    logic [1:0] last_col = TK_EMPTY;
    int         bad_step = 0;
    logic       got_q [$];

    always #5 clk = ~clk;

    yc_redport #(.SYNC_STAGES(SYNC), .TIMEOUT_W(16), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit),
        .err(err), .col_uempty(col_uempty), .col_out(col_out), .col_back(col_back)
    );

    yc_redport #(.SYNC_STAGES(SYNC), .TIMEOUT_W(16), .TIMEOUT(0)) dut_nt (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_nt), .in_ready(in_ready_nt), .in_bit(1'b1),
        .res_valid(res_valid_nt), .res_ready(1'b1), .res_bit(res_bit_nt),
        .err(err_nt), .col_uempty(col_uempty_nt), .col_out(col_out_nt), .col_back(2'b00)
    );

    function automatic logic [1:0] invert_tok(input logic [1:0] t);
        case (t)
            TK_ZERO: return TK_ONE;
            TK_ONE:  return TK_ZERO;
            default: return t;
        endcase
    endfunction

    // Column model: a 5-cycle delay line from col_out back to col_back.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) hist[i] <= TK_EMPTY;
        end else begin
            hist[0] <= col_out;
            for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
        end
    end

    assign col_back = (col_mode == COL_MANUAL) ? man_back :
                      (col_mode == COL_ECHO)   ? hist[4]  : invert_tok(hist[4]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && res_valid && res_ready) got_q.push_back(res_bit);
        if ((last_col == TK_ZERO && col_out == TK_ONE) || (last_col == TK_ONE && col_out == TK_ZERO))
            bad_step <= bad_step + 1;
        last_col <= col_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int w = 0;
        while (in_ready !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(tag, in_ready, 1);
    endtask

    task automatic send(input logic b, input int budget);
        in_bit   = b;
        in_valid = 1'b1;
        wait_ready("send_ready", budget);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_res(input string tag, input int budget);
        int w = 0;
        while (res_valid !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(tag, res_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         rel;
        int         viol;
        int         w;
        logic [7:0] bits;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        res_ready   = 1'b0;
        in_valid_nt = 1'b0;
        tick(3);

        check("rst_col_out",    col_out,    TK_EMPTY);
        check("rst_in_ready",   in_ready,   0);
        check("rst_res_valid",  res_valid,  0);
        check("rst_res_bit",    res_bit,    0);
        check("rst_err",        err,        0);
        check("rst_col_uempty", col_uempty, 0);

        reset = 1'b0;
        rel   = cyc;
        wait_ready("ready_after_reset", 8);
        check("ready_after_reset_lat", (cyc - rel) <= SYNC + 2, 1);

        $display("[TB] echo column, bit 1");
        col_mode  = COL_ECHO;
        res_ready = 1'b1;
        send(1'b1, 20);
        check("A_col_out_drive", col_out, TK_ONE);
        wait_res("A_res_seen", 40);
        check("A_res_latency", cyc - acc_cyc, 10);
        check("A_res_bit",     res_bit, 1);
        check("A_col_released", col_out, TK_EMPTY);
        wait_ready("A_ready_again", 40);
        check("A_ready_latency", cyc - acc_cyc, 20);
        check("A_col_back_empty", col_back, TK_EMPTY);

        $display("[TB] NOT column, stalled consumer");
        col_mode  = COL_NOT;
        res_ready = 1'b0;
        send(1'b0, 20);
        check("B_col_out_drive", col_out, TK_ZERO);
        wait_res("B_res_seen", 40);
        check("B_res_latency", cyc - acc_cyc, 10);
        check("B_res_bit", res_bit, 1);
        in_bit   = 1'b1;
        in_valid = 1'b1;
        viol     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_bit !== 1'b1 || in_ready !== 1'b0 || col_out !== TK_EMPTY)
                viol++;
        end
        check("B_hold_violations", viol, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("B_res_consumed", res_valid, 0);
        check("B_ready_after_consume", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
        check("B_second_accepted", col_out, TK_ONE);
        wait_res("B_res2_seen", 40);
        check("B_res2_bit", res_bit, 0);
        res_ready = 1'b1;
        wait_ready("B_ready_end", 40);

        $display("[TB] skewed column wires");
        col_mode = COL_MANUAL;
        man_back = TK_EMPTY;
        send(1'b1, 20);
        check("C_col_out_drive", col_out, TK_ONE);
        tick(3);
        man_back = TK_ILLEGAL;
        tick(1);
        man_back = TK_ONE;
        wait_res("C_res_seen", 20);
        check("C_res_bit", res_bit, 1);
        check("C_err_masked", err, 0);
        man_back = TK_EMPTY;
        wait_ready("C_ready_again", 20);
        send(1'b0, 20);
        tick(3);
        man_back = TK_ILLEGAL;
        tick(4);
        man_back = TK_EMPTY;
        tick(6);
        check("C_err_illegal", err, 1);
        check("C_err_col_out", col_out, TK_EMPTY);
        check("C_err_in_ready", in_ready, 0);
        check("C_err_res_valid", res_valid, 0);

        $display("[TB] timeout");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("D_err_cleared", err, 0);
        wait_ready("D_ready", 8);
        send(1'b1, 20);
        w = 0;
        while (err !== 1'b1 && w < 80) begin
            @(negedge clk);
            w++;
        end
        check("D_timeout_latency", cyc - acc_cyc, 50);
        check("D_timeout_col_out", col_out, TK_EMPTY);

        $display("[TB] reset during drive");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_ready("E_ready", 8);
        send(1'b1, 20);
        tick(5);
        check("E_still_driving", col_out, TK_ONE);
        reset = 1'b1;
        #1;
        check("E_async_col_out", col_out, TK_EMPTY);
        check("E_async_in_ready", in_ready, 0);
        check("E_async_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc;
        wait_ready("E_ready_after_release", 8);
        check("E_ready_latency", (cyc - rel) <= SYNC + 2, 1);

        $display("[TB] bit stream through echo column");
        col_mode  = COL_ECHO;
        res_ready = 1'b1;
        got_q.delete();
        bits = 8'b10110010;
        for (int i = 7; i >= 0; i--) begin
            send(bits[i], 40);
            wait_res("F_res_seen", 40);
            check("F_res_bit", res_bit, bits[i]);
        end
        tick(2);
        check("F_result_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) check("F_result_order", got_q[i], bits[7-i]);
        end
        check("F_no_direct_flip", bad_step, 0);

        $display("[TB] timeout disabled instance");
        in_valid_nt = 1'b1;
        w = 0;
        while (in_ready_nt !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("G_ready", in_ready_nt, 1);
        @(negedge clk);
        in_valid_nt = 1'b0;
        tick(10000);
        check("G_no_err", err_nt, 0);
        check("G_still_driving", col_out_nt, TK_ONE);
        check("G_no_result", res_valid_nt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
